keypad_code_checker: RTL and testbench
======================================

# keypad_code_checker

Consumer of the keypad's one-cycle digit pulses (`input_v`, `index`). It collects a fixed-length PIN, compares it with the stored code, and drives the lock: timed unlock, failure counting with timed lockout, and code change while the door is unlocked. It sits directly downstream of the keypad front-end in the doorlock top.

## Interface
Parameters:
- `CODE_LEN`, 4: digits per PIN, range 1..8.
- `DEFAULT_CODE`, 32'h0000_1234: code after reset, BCD. Only the low `CODE_LEN`*4 bits are used. The first-entered digit is the most significant nibble.
- `OPEN_CYCLES`, 50_000_000: cycles `unlock` stays high.
- `LOCK_CYCLES`, 500_000_000: lockout duration in cycles.
- `TIMEOUT_CYCLES`, 250_000_000: idle cycles allowed between digits.
- `MAX_FAIL`, 3: consecutive failures that trigger lockout.

Ports:
- `clk` in 1: the single clock.
- `rstn` in 1: asynchronous, active-low reset.
- `input_v` in 1: one-cycle digit strobe.
- `index` in 4: digit value, valid when `input_v` is high.
- `change_req` in 1: one-cycle request to program a new code.
- `unlock` out 1: level, drives the lock actuator.
- `locked` out 1: level, high during lockout.
- `fail` out 1: one-cycle pulse on a wrong PIN.
- `code_set` out 1: one-cycle pulse when a new code is committed.
- `digit_cnt` out 4: number of digits collected so far, for the display.

## Operation
- States: IDLE, ENTRY, OPEN, LOCKOUT, SET.
- Digit acceptance:
  - A digit is accepted only when `input_v`=1, `index`<=9, and the state is IDLE, ENTRY or SET.
  - Strobes with `index`>=10 are dropped and do not restart the timeout.
  - Every `input_v` is ignored in OPEN and LOCKOUT.
  - An accepted digit shifts into the entry buffer (`CODE_LEN`*4 bits) from the LS side and increments `digit_cnt`.
- IDLE -> ENTRY on the first accepted digit.
- ENTRY:
  - The `CODE_LEN`-th digit compares the buffer (including that digit) with the stored code.
  - Match -> OPEN; `fail_cnt` cleared.
  - Mismatch -> `fail`, `fail_cnt`+1. Next state is LOCKOUT if the new `fail_cnt` equals `MAX_FAIL`, otherwise IDLE.
  - The buffer and `digit_cnt` clear on either outcome.
- Timeout: in ENTRY and SET, `TIMEOUT_CYCLES` consecutive cycles with no accepted digit -> IDLE.
  - Buffer cleared.
  - `fail_cnt` unchanged.
  - A SET timeout keeps the old code.
- OPEN:
  - `unlock`=1 for exactly `OPEN_CYCLES` cycles, then IDLE.
  - `change_req` in OPEN -> SET immediately; `unlock` drops.
- SET:
  - Collects `CODE_LEN` digits.
  - On the last digit, the buffer (including that digit) becomes the stored code, `code_set` pulses, next state is IDLE.
- `change_req` outside OPEN is ignored.
- LOCKOUT: `locked`=1 for exactly `LOCK_CYCLES` cycles, then IDLE with `fail_cnt`=0.
- Simultaneous events:
  - `change_req` on the last OPEN cycle: SET wins.
  - Accepted digit on the cycle the timeout would expire: the digit wins and the timeout restarts.
- Reset mid-operation: all state is lost and the stored code returns to `DEFAULT_CODE`.

## Timing
- Reset values: `unlock`=0, `locked`=0, `fail`=0, `code_set`=0, `digit_cnt`=0, state IDLE, `fail_cnt`=0, buffer 0, stored code = `DEFAULT_CODE`.
- All outputs are registered.
- Final digit sampled at edge t:
  - `unlock` or `fail` or `code_set` is high from edge t to edge t+1.
  - `digit_cnt` reads 0 after edge t.
- `unlock`: high after edge t, low after edge t+`OPEN_CYCLES`.
- `locked` behaves the same way with `LOCK_CYCLES`.
- Timeout counting:
  - The last accepted digit at edge t gives an IDLE transition at edge t+`TIMEOUT_CYCLES`.
  - An accepted digit at edge t+k, with k<=`TIMEOUT_CYCLES`, restarts the count.
- `change_req` sampled at edge t in OPEN: state SET and `unlock`=0 after edge t.
- `digit_cnt` updates on the same edge the digit is accepted.
- Width rules:
  - Timer width is `$clog2` of the largest of the three cycle parameters, plus 1.
  - `fail_cnt` width is `$clog2(MAX_FAIL+1)`.

## Structure
- Shared package `doorlock_pkg` holds:
  - the state enum;
  - `DIGIT_W`=4;
  - `INDEX_NONE`=4'hF;
  - `MAX_DIGIT`=9.
  The keypad front-end uses the same constants.
- One sub-module, `cycle_timer`: a loadable down-counter with a `done` pulse, shared by the OPEN, LOCKOUT and timeout durations. It is reloaded on every state entry and on every accepted digit.

## Test plan
Bench parameters: `CODE_LEN`=4, `DEFAULT_CODE`=32'h1234, `OPEN_CYCLES`=8, `LOCK_CYCLES`=16, `TIMEOUT_CYCLES`=20, `MAX_FAIL`=3.
- Correct PIN: digits 1,2,3,4, pulses 3 cycles apart -> `unlock` high for exactly 8 cycles starting the cycle after digit 4; `digit_cnt` steps 1,2,3 then reads 0; `fail` stays 0.
- Three wrong PINs (1,2,3,5 each) -> `fail` pulses three times; `locked` high for 16 cycles after the third; a correct PIN entered during lockout gives no `unlock`; a correct PIN entered after lockout unlocks.
- Entry timeout: digits 1,2, then 20 idle cycles -> `digit_cnt` returns to 0; then 1,2,3,4 -> unlock; `fail` never pulses.
- Code change: unlock, `change_req` on cycle 3 of OPEN -> `unlock` drops the next cycle; enter 9,8,7,6 -> `code_set` pulse; 1,2,3,4 -> `fail`; 9,8,7,6 -> `unlock`.
- Edge cases:
  - `index`=4'hA strobes are ignored and do not restart the timeout.
  - `input_v` during OPEN is ignored.
  - `change_req` on the last OPEN cycle enters SET.
  - `rstn` asserted mid-SET restores code 1234 and clears all outputs.

Source files
------------

// File: rtl/doorlock_pkg.sv
// -----------------------------------------------------------------------------
// doorlock_pkg
// Shared constants and types for the door-lock keypad path. The keypad
// front-end and keypad_code_checker both import this package.
//   DIGIT_W    : width of one BCD digit / key index
//   INDEX_NONE : key index used when no key is pressed
//   MAX_DIGIT  : largest key index that is a decimal digit
//   state_t    : code-checker state encoding
//   max3       : largest of three values, used to size shared counters
// -----------------------------------------------------------------------------
package doorlock_pkg;

  localparam int         DIGIT_W    = 4;
  localparam logic [3:0] INDEX_NONE = 4'hF;
  localparam logic [3:0] MAX_DIGIT  = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_OPEN    = 3'd2,
    ST_LOCKOUT = 3'd3,
    ST_SET     = 3'd4
  } state_t;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage

// File: rtl/keypad_code_checker_if.sv
// -----------------------------------------------------------------------------
// keypad_code_checker_if
// Bundles the digit strobe, code-change request and lock status outputs.
//   master : keypad side / environment (drives input_v, index, change_req)
//   slave  : keypad_code_checker (drives unlock, locked, fail, code_set,
//            digit_cnt)
// -----------------------------------------------------------------------------
interface keypad_code_checker_if;
  import doorlock_pkg::*;

  logic               input_v;
  logic [DIGIT_W-1:0] index;
  logic               change_req;
  logic               unlock;
  logic               locked;
  logic               fail;
  logic               code_set;
  logic [3:0]         digit_cnt;

  modport master (
    output input_v, index, change_req,
    input  unlock, locked, fail, code_set, digit_cnt
  );

  modport slave (
    input  input_v, index, change_req,
    output unlock, locked, fail, code_set, digit_cnt
  );

endinterface

// File: rtl/keypad_code_checker_cycle_timer.sv
// -----------------------------------------------------------------------------
// cycle_timer
// Loadable down-counter. Loading N makes o_done assert during the N-th cycle
// after the load edge, so a state whose transition follows o_done lasts
// exactly N cycles. Loading 0 keeps the timer silent.
//   clk, rstn : clock, asynchronous active-low reset
//   i_load    : load i_value this cycle (takes priority over counting)
//   i_value   : reload value
//   o_done    : high while one cycle remains
// -----------------------------------------------------------------------------
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_done
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] r_count;

  // Reload or count down towards zero, then hold at zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - ONE;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_done = (r_count == ONE);

endmodule

// File: rtl/keypad_code_checker.sv
// -----------------------------------------------------------------------------
// keypad_code_checker
// Collects CODE_LEN decimal digits, compares them with the stored code and
// drives the lock: timed unlock, consecutive-failure lockout, and programming
// a new code from the unlocked state.
//   clk, rstn : clock, asynchronous active-low reset
//   kif       : slave side of keypad_code_checker_if
//               in : input_v, index, change_req
//               out: unlock, locked, fail, code_set, digit_cnt (all registered)
// -----------------------------------------------------------------------------
module keypad_code_checker
  import doorlock_pkg::*;
#(
  parameter int          CODE_LEN       = 4,
  parameter logic [31:0] DEFAULT_CODE   = 32'h0000_1234,
  parameter int unsigned OPEN_CYCLES    = 50_000_000,
  parameter int unsigned LOCK_CYCLES    = 500_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000,
  parameter int unsigned MAX_FAIL       = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  keypad_code_checker_if.slave  kif
);

  localparam int BUF_W  = CODE_LEN * DIGIT_W;
  localparam int TMR_W  = $clog2(max3(OPEN_CYCLES, LOCK_CYCLES, TIMEOUT_CYCLES)) + 1;
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);

  localparam logic [TMR_W-1:0]  OPEN_V     = TMR_W'(OPEN_CYCLES);
  localparam logic [TMR_W-1:0]  LOCK_V     = TMR_W'(LOCK_CYCLES);
  localparam logic [TMR_W-1:0]  TOUT_V     = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [FAIL_W-1:0] MAX_FAIL_V = FAIL_W'(MAX_FAIL);
  localparam logic [FAIL_W-1:0] FAIL_ONE   = FAIL_W'(1);
  localparam logic [3:0]        LAST_CNT   = 4'(CODE_LEN - 1);
  localparam logic [BUF_W-1:0]  DEF_CODE   = DEFAULT_CODE[BUF_W-1:0];

  state_t            r_state, w_state_nxt;
  logic [BUF_W-1:0]  r_buf, w_buf_nxt;
  logic [BUF_W-1:0]  r_code, w_code_nxt;
  logic [FAIL_W-1:0] r_fail_cnt, w_fail_cnt_nxt;
  logic [3:0]        r_digit_cnt, w_cnt_nxt;
  logic              r_unlock, r_locked, r_fail, r_code_set;
  logic              w_unlock_nxt, w_locked_nxt, w_fail_nxt, w_code_set_nxt;
  logic              w_fail_ev, w_set_ev;

  logic              w_digit_ok, w_accept, w_last;
  logic [BUF_W-1:0]  w_shifted;
  logic [FAIL_W-1:0] w_fail_inc;
  logic              w_tmr_load, w_tmr_done;
  logic [TMR_W-1:0]  w_tmr_value;

  assign w_digit_ok = kif.input_v && (kif.index <= MAX_DIGIT);
  assign w_accept   = w_digit_ok &&
                      ((r_state == ST_IDLE) || (r_state == ST_ENTRY) || (r_state == ST_SET));
  assign w_last     = (r_digit_cnt == LAST_CNT);
  // First digit ends up in the most significant nibble after CODE_LEN shifts.
  assign w_shifted  = BUF_W'({r_buf, kif.index});
  assign w_fail_inc = r_fail_cnt + FAIL_ONE;

  // Every state change and every accepted digit restarts the shared timer
  // with the duration that belongs to the state being entered.
  assign w_tmr_load = (w_state_nxt != r_state) || w_accept;

  // Select the reload value for the upcoming state.
  always_comb begin
    w_tmr_value = '0;
    case (w_state_nxt)
      ST_OPEN:          w_tmr_value = OPEN_V;
      ST_LOCKOUT:       w_tmr_value = LOCK_V;
      ST_ENTRY, ST_SET: w_tmr_value = TOUT_V;
      default:          w_tmr_value = '0;
    endcase
  end

  cycle_timer #(.W(TMR_W)) u_timer (
    .clk     (clk),
    .rstn    (rstn),
    .i_load  (w_tmr_load),
    .i_value (w_tmr_value),
    .o_done  (w_tmr_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath-next logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_buf_nxt      = r_buf;
    w_code_nxt     = r_code;
    w_fail_cnt_nxt = r_fail_cnt;
    w_cnt_nxt      = r_digit_cnt;
    w_fail_ev      = 1'b0;
    w_set_ev       = 1'b0;
    case (r_state)
      ST_IDLE, ST_ENTRY: begin
        if (w_digit_ok) begin
          if (w_last) begin
            w_buf_nxt = '0;
            w_cnt_nxt = 4'd0;
            if (w_shifted == r_code) begin
              w_state_nxt    = ST_OPEN;
              w_fail_cnt_nxt = '0;
            end else begin
              w_fail_ev      = 1'b1;
              w_fail_cnt_nxt = w_fail_inc;
              w_state_nxt    = (w_fail_inc == MAX_FAIL_V) ? ST_LOCKOUT : ST_IDLE;
            end
          end else begin
            w_buf_nxt   = w_shifted;
            w_cnt_nxt   = r_digit_cnt + 4'd1;
            w_state_nxt = ST_ENTRY;
          end
        end else if ((r_state == ST_ENTRY) && w_tmr_done) begin
          w_state_nxt = ST_IDLE;
          w_buf_nxt   = '0;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_OPEN: begin
        // A change request beats the unlock expiry on the same cycle.
        if (kif.change_req) begin
          w_state_nxt = ST_SET;
        end else if (w_tmr_done) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_OPEN;
        end
      end
      ST_LOCKOUT: begin
        if (w_tmr_done) begin
          w_state_nxt    = ST_IDLE;
          w_fail_cnt_nxt = '0;
        end else begin
          w_state_nxt = ST_LOCKOUT;
        end
      end
      ST_SET: begin
        if (w_digit_ok) begin
          if (w_last) begin
            w_code_nxt  = w_shifted;
            w_set_ev    = 1'b1;
            w_buf_nxt   = '0;
            w_cnt_nxt   = 4'd0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_buf_nxt = w_shifted;
            w_cnt_nxt = r_digit_cnt + 4'd1;
          end
        end else if (w_tmr_done) begin
          // Abandoned programming keeps the previous code.
          w_state_nxt = ST_IDLE;
          w_buf_nxt   = '0;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_state_nxt = ST_SET;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_buf_nxt   = '0;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    w_unlock_nxt   = (w_state_nxt == ST_OPEN);
    w_locked_nxt   = (w_state_nxt == ST_LOCKOUT);
    w_fail_nxt     = w_fail_ev;
    w_code_set_nxt = w_set_ev;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_buf       <= '0;
      r_code      <= DEF_CODE;
      r_fail_cnt  <= '0;
      r_digit_cnt <= 4'd0;
      r_unlock    <= 1'b0;
      r_locked    <= 1'b0;
      r_fail      <= 1'b0;
      r_code_set  <= 1'b0;
    end else begin
      r_buf       <= w_buf_nxt;
      r_code      <= w_code_nxt;
      r_fail_cnt  <= w_fail_cnt_nxt;
      r_digit_cnt <= w_cnt_nxt;
      r_unlock    <= w_unlock_nxt;
      r_locked    <= w_locked_nxt;
      r_fail      <= w_fail_nxt;
      r_code_set  <= w_code_set_nxt;
    end
  end

  assign kif.unlock    = r_unlock;
  assign kif.locked    = r_locked;
  assign kif.fail      = r_fail;
  assign kif.code_set  = r_code_set;
  assign kif.digit_cnt = r_digit_cnt;

endmodule

// File: tb/tb_keypad_code_checker.sv
// -----------------------------------------------------------------------------
// tb_keypad_code_checker
// Directed stimulus against keypad_code_checker. A behavioural model tracks
// the lock using absolute cycle deadlines and a digit queue; a compare process
// checks every output one time unit after each rising edge, and the stimulus
// also checks hand-computed literals (pulse counts, high-cycle counts,
// digit_cnt values at timing boundaries).
// -----------------------------------------------------------------------------
module tb_keypad_code_checker;
  import doorlock_pkg::*;

  localparam int LEN  = 4;
  localparam int OPEN = 8;
  localparam int LOCK = 16;
  localparam int TOUT = 20;
  localparam int MAXF = 3;

  localparam int M_IDLE  = 0;
  localparam int M_ENTRY = 1;
  localparam int M_OPEN  = 2;
  localparam int M_LOCK  = 3;
  localparam int M_SET   = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  keypad_code_checker_if kif ();

  keypad_code_checker #(
    .CODE_LEN       (LEN),
    .DEFAULT_CODE   (32'h0000_1234),
    .OPEN_CYCLES    (OPEN),
    .LOCK_CYCLES    (LOCK),
    .TIMEOUT_CYCLES (TOUT),
    .MAX_FAIL       (MAXF)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .kif  (kif.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int cyc      = 0;
  int mode     = M_IDLE;
  int q[$];
  int code     = 'h1234;
  int fails    = 0;
  int open_end = 0;
  int lock_end = 0;
  int last_dig = 0;
  int e_unlock = 0, e_locked = 0, e_fail = 0, e_set = 0, e_cnt = 0;

  // Model step at every edge: deadlines are absolute cycle numbers.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cyc = 0; mode = M_IDLE; q.delete(); code = 'h1234; fails = 0;
      e_unlock = 0; e_locked = 0; e_fail = 0; e_set = 0; e_cnt = 0;
    end else begin
      int v;
      bit acc;
      cyc++;
      e_fail = 0;
      e_set  = 0;
      acc = kif.input_v && (kif.index <= 4'd9) &&
            (mode == M_IDLE || mode == M_ENTRY || mode == M_SET);
      if (mode == M_OPEN) begin
        if (kif.change_req) begin
          mode = M_SET; last_dig = cyc;
        end else if (cyc == open_end) begin
          mode = M_IDLE;
        end
      end else if (mode == M_LOCK) begin
        if (cyc == lock_end) begin
          mode = M_IDLE; fails = 0;
        end
      end else if (acc) begin
        q.push_back(int'(kif.index));
        last_dig = cyc;
        if (q.size() == LEN) begin
          v = 0;
          foreach (q[i]) v = v * 16 + q[i];
          q.delete();
          if (mode == M_SET) begin
            code = v; e_set = 1; mode = M_IDLE;
          end else if (v == code) begin
            mode = M_OPEN; open_end = cyc + OPEN; fails = 0;
          end else begin
            fails++; e_fail = 1;
            if (fails == MAXF) begin
              mode = M_LOCK; lock_end = cyc + LOCK;
            end else begin
              mode = M_IDLE;
            end
          end
        end else if (mode == M_IDLE) begin
          mode = M_ENTRY;
        end
      end else if ((mode == M_ENTRY || mode == M_SET) && (cyc - last_dig == TOUT)) begin
        mode = M_IDLE; q.delete();
      end
      e_unlock = (mode == M_OPEN);
      e_locked = (mode == M_LOCK);
      e_cnt    = q.size();
    end
  end

  // ---------------- compare process ----------------
  int t_unlock = 0, t_locked = 0, t_fail = 0, t_set = 0;

  always @(posedge clk) begin
    #1;
    chk("unlock",    int'(kif.unlock),    e_unlock);
    chk("locked",    int'(kif.locked),    e_locked);
    chk("fail",      int'(kif.fail),      e_fail);
    chk("code_set",  int'(kif.code_set),  e_set);
    chk("digit_cnt", int'(kif.digit_cnt), e_cnt);
    t_unlock += int'(kif.unlock);
    t_locked += int'(kif.locked);
    t_fail   += int'(kif.fail);
    t_set    += int'(kif.code_set);
  end

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] d);
    kif.index   = d;
    kif.input_v = 1'b1;
    @(negedge clk);
    kif.input_v = 1'b0;
    kif.index   = INDEX_NONE;
  endtask

  task automatic pin(input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] c, input logic [3:0] d);
    press(a); idle(2);
    press(b); idle(2);
    press(c); idle(2);
    press(d); idle(2);
  endtask

  task automatic change();
    kif.change_req = 1'b1;
    @(negedge clk);
    kif.change_req = 1'b0;
  endtask

  task automatic clr();
    t_unlock = 0; t_locked = 0; t_fail = 0; t_set = 0;
  endtask

  initial begin
    kif.input_v    = 1'b0;
    kif.index      = INDEX_NONE;
    kif.change_req = 1'b0;
    idle(3);
    chk("rst_unlock", int'(kif.unlock),    0);
    chk("rst_locked", int'(kif.locked),    0);
    chk("rst_cnt",    int'(kif.digit_cnt), 0);
    rstn = 1'b1;
    idle(2);

    // Correct PIN, digits 3 cycles apart.
    clr();
    press(4'd1); chk("cnt_1", int'(kif.digit_cnt), 1); idle(2);
    press(4'd2); chk("cnt_2", int'(kif.digit_cnt), 2); idle(2);
    press(4'd3); chk("cnt_3", int'(kif.digit_cnt), 3); idle(2);
    press(4'd4); chk("cnt_done", int'(kif.digit_cnt), 0);
    chk("unlock_now", int'(kif.unlock), 1);
    idle(10);
    chk("open_len", t_unlock, 8);
    chk("ok_nofail", t_fail, 0);

    // Three wrong PINs then lockout; correct PIN during lockout ignored.
    clr();
    repeat (3) pin(4'd1, 4'd2, 4'd3, 4'd5);
    chk("fail_pulses", t_fail, 3);
    chk("locked_now", int'(kif.locked), 1);
    pin(4'd1, 4'd2, 4'd3, 4'd4);
    idle(4);
    chk("lock_no_unlock", t_unlock, 0);
    chk("lock_len", t_locked, 16);
    clr();
    pin(4'd1, 4'd2, 4'd3, 4'd4);
    idle(8);
    chk("post_lock_open", t_unlock, 8);

    // Entry timeout at exactly 20 idle cycles.
    clr();
    press(4'd1); idle(2);
    press(4'd2); idle(19);
    chk("tout_before", int'(kif.digit_cnt), 2);
    idle(1);
    chk("tout_after", int'(kif.digit_cnt), 0);
    pin(4'd1, 4'd2, 4'd3, 4'd4);
    idle(8);
    chk("tout_open", t_unlock, 8);
    chk("tout_nofail", t_fail, 0);

    // Code change: change_req on OPEN cycle 3.
    clr();
    pin(4'd1, 4'd2, 4'd3, 4'd4);
    change();
    chk("chg_drop", int'(kif.unlock), 0);
    pin(4'd9, 4'd8, 4'd7, 4'd6);
    chk("chg_set", t_set, 1);
    pin(4'd1, 4'd2, 4'd3, 4'd4);
    chk("old_code_fail", t_fail, 1);
    pin(4'd9, 4'd8, 4'd7, 4'd6);
    idle(8);
    chk("new_code_open", t_unlock, 11);

    // Non-digit strobes do not restart the timeout.
    press(4'd1); idle(4);
    press(INDEX_NONE); idle(4);
    press(4'hA); idle(9);
    chk("hex_before", int'(kif.digit_cnt), 1);
    idle(1);
    chk("hex_after", int'(kif.digit_cnt), 0);

    // Digit on the expiry cycle wins; digits during OPEN ignored.
    clr();
    press(4'd9); idle(19);
    press(4'd8);
    chk("edge_digit", int'(kif.digit_cnt), 2);
    idle(2); press(4'd7); idle(2); press(4'd6);
    chk("edge_open", int'(kif.unlock), 1);
    press(4'd5); press(4'd6);
    chk("open_ignore", int'(kif.digit_cnt), 0);
    idle(8);
    chk("open_ignore_after", int'(kif.digit_cnt), 0);

    // change_req on the last OPEN cycle enters SET.
    pin(4'd9, 4'd8, 4'd7, 4'd6);
    idle(5);
    change();
    chk("last_drop", int'(kif.unlock), 0);
    clr();
    pin(4'd5, 4'd5, 4'd5, 4'd5);
    chk("last_set", t_set, 1);

    // Reset in the middle of SET restores the default code.
    pin(4'd5, 4'd5, 4'd5, 4'd5);
    change();
    press(4'd1); idle(2); press(4'd2);
    chk("set_cnt", int'(kif.digit_cnt), 2);
    rstn = 1'b0;
    #1;
    chk("mid_rst_cnt",    int'(kif.digit_cnt), 0);
    chk("mid_rst_unlock", int'(kif.unlock),    0);
    chk("mid_rst_locked", int'(kif.locked),    0);
    @(negedge clk);
    rstn = 1'b1;
    idle(2);
    clr();
    pin(4'd5, 4'd5, 4'd5, 4'd5);
    chk("rst_old_fail", t_fail, 1);
    pin(4'd1, 4'd2, 4'd3, 4'd4);
    idle(8);
    chk("rst_default_open", t_unlock, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
